// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the single-beat AXI3 SRAM slave.
// Holds write-FSM encodings, response codes and the backpressure LFSR.
package axi_slave_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wstate_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int         LFSR_W    = 8;
    // Taps 8,6,5,4 in 1-based numbering map to bits 7,5,4,3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axi_slave_rq_fifo.sv
// In-order read response queue for the AXI SRAM slave.
// Entries carry {id, data}; storage resets to zero so the head reads 0 out of reset.
module axi_slave_rq_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave backed by a local word memory.
// Define AXI_SLAVE_DELAY_EN for LFSR-driven pseudo-random backpressure.
module axi_sram_slave
    import axi_slave_pkg::*;
#(
    parameter int          MEM_AW    = 12,
    parameter int          RQ_DEPTH  = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int MEM_DEPTH = 1 << MEM_AW;

    logic [31:0]       mem [MEM_DEPTH];
    wstate_t           state_q;
    wstate_t           state_d;
    logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic              commit;
    logic              ar_gate, wr_gate;
    logic [MEM_AW-1:0] aw_idx_q, cm_idx, ar_idx;
    logic [31:0]       w_data_q, cm_data, rd_word;
    logic [3:0]        w_strb_q, cm_strb, bid_q;
    logic              rq_full, rq_empty;
    logic [35:0]       rq_head;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;
    assign b_hs  = bvalid && bready;
    assign r_hs  = rvalid && rready;

    assign awready = wr_gate &&
                     (state_q == W_IDLE || state_q == W_HAVE_W);
    assign wready  = wr_gate &&
                     (state_q == W_IDLE || state_q == W_HAVE_AW);
    assign arready = ar_gate && !rq_full;

    assign rresp = RESP_OKAY;
    assign bresp = RESP_OKAY;
    assign rlast = 1'b1;
    assign bid   = bid_q;
    assign rid   = rq_head[35:32];
    assign rdata = rq_head[31:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) state_d = W_RESP;
                else if (aw_hs)    state_d = W_HAVE_AW;
                else if (w_hs)     state_d = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)  state_d = W_RESP;
            W_HAVE_W:  if (aw_hs) state_d = W_RESP;
            W_RESP:    if (b_hs)  state_d = W_IDLE;
            default:   state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) state_q <= W_IDLE;
        else       state_q <= state_d;
    end

    // The commit edge is the one that completes the AW/W pair.
    assign commit  = (state_d == W_RESP) && (state_q != W_RESP);
    assign cm_idx  = aw_hs ? awaddr[MEM_AW+1:2] : aw_idx_q;
    assign cm_data = w_hs ? wdata : w_data_q;
    assign cm_strb = w_hs ? wstrb : w_strb_q;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            aw_idx_q <= '0;
            bid_q    <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_idx_q <= awaddr[MEM_AW+1:2];
                bid_q    <= awid;
            end
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (commit && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_strb[b]) mem[cm_idx][b*8 +: 8] <= cm_data[b*8 +: 8];
            end
        end
    end

    // Same-cycle write to the read word forwards the strobed bytes.
    assign ar_idx = araddr[MEM_AW+1:2];
    always_comb begin
        rd_word = mem[ar_idx];
        for (int b = 0; b < 4; b++) begin
            if (commit && cm_idx == ar_idx && cm_strb[b]) begin
                rd_word[b*8 +: 8] = cm_data[b*8 +: 8];
            end
        end
    end

    axi_slave_rq_fifo #(
        .W     (36),
        .DEPTH (RQ_DEPTH)
    ) u_rq (
        .clk   (aclk),
        .reset (reset),
        .push  (ar_hs),
        .pop   (r_hs),
        .din   ({arid, rd_word}),
        .full  (rq_full),
        .empty (rq_empty),
        .head  (rq_head)
    );

`ifdef AXI_SLAVE_DELAY_EN
    logic [LFSR_W-1:0] lfsr_q;
    logic              r_armed, b_armed;
    logic [1:0]        r_cnt, b_cnt;

    assign ar_gate = lfsr_q[0];
    assign wr_gate = lfsr_q[1];
    assign rvalid  = !rq_empty && r_armed && (r_cnt == 2'd0);
    assign bvalid  = (state_q == W_RESP) && b_armed && (b_cnt == 2'd0);

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_next(lfsr_q);
    end

    // Each new head/B arms a wait count; valid holds once the count expires.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
            b_armed <= 1'b0;
            b_cnt   <= '0;
        end else begin
            if (r_hs) begin
                r_armed <= 1'b0;
            end else if (!rq_empty && !r_armed) begin
                r_armed <= 1'b1;
                r_cnt   <= lfsr_q[3:2];
            end else if (r_armed && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (b_hs) begin
                b_armed <= 1'b0;
            end else if (state_q == W_RESP && !b_armed) begin
                b_armed <= 1'b1;
                b_cnt   <= lfsr_q[5:4];
            end else if (b_armed && b_cnt != 2'd0) begin
                b_cnt <= b_cnt - 1'b1;
            end
        end
    end
`else
    assign ar_gate = 1'b1;
    assign wr_gate = 1'b1;
    assign rvalid  = !rq_empty;
    assign bvalid  = (state_q == W_RESP);
`endif

    logic unused_ok;
    assign unused_ok = ^{arlen, arsize, arburst, arlock, arcache, arprot,
                         awlen, awsize, awburst, awlock, awcache, awprot,
                         wid, wlast, LFSR_SEED,
                         araddr[31:MEM_AW+2], araddr[1:0],
                         awaddr[31:MEM_AW+2], awaddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus
// randomized traffic checked against a word-array reference memory.
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int total = 0;
    int bad   = 0;

    bit [31:0] model [4096];

    always #5 aclk = ~aclk;

    axi_sram_slave dut (
        .aclk    (aclk),
        .reset   (reset),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (4'd0),
        .arsize  (3'd2),
        .arburst (2'd1),
        .arlock  (2'd0),
        .arcache (4'd0),
        .arprot  (3'd0),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (4'd0),
        .awsize  (3'd2),
        .awburst (2'd1),
        .awlock  (2'd0),
        .awcache (4'd0),
        .awprot  (3'd0),
        .awvalid (awvalid),
        .awready (awready),
        .wid     (4'd0),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (1'b1),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic bit [31:0] merge(input bit [31:0] old_w,
                                        input bit [31:0] new_w,
                                        input bit [3:0]  strb);
        bit [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // mode 0: AW and W together, 1: W first, 2: AW first
    task automatic do_write(input bit [3:0] id, input bit [31:0] addr,
                            input bit [31:0] data, input bit [3:0] strb,
                            input int mode, input int gap,
                            output logic [3:0] got_bid, output bit tmo);
        int n;
        tmo = 0;
        awid = id; awaddr = addr; wdata = data; wstrb = strb;
        if (mode == 0) begin
            awvalid = 1; wvalid = 1;
            n = 0;
            while (!(awready && wready) && n < 50) begin tick(); n++; end
            if (n == 50) tmo = 1;
            tick();
            awvalid = 0; wvalid = 0;
        end else begin
            if (mode == 1) wvalid = 1; else awvalid = 1;
            n = 0;
            while (!(mode == 1 ? wready : awready) && n < 50) begin
                tick(); n++;
            end
            if (n == 50) tmo = 1;
            tick();
            wvalid = 0; awvalid = 0;
            repeat (gap) tick();
            if (mode == 1) awvalid = 1; else wvalid = 1;
            n = 0;
            while (!(mode == 1 ? awready : wready) && n < 50) begin
                tick(); n++;
            end
            if (n == 50) tmo = 1;
            tick();
            wvalid = 0; awvalid = 0;
        end
        model[addr[13:2]] = merge(model[addr[13:2]], data, strb);
        bready = 1;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (!bvalid) tmo = 1;
        got_bid = bid;
        tick();
        bready = 0;
    endtask

    task automatic do_read(input bit [3:0] id, input bit [31:0] addr,
                           output logic [3:0] got_id,
                           output logic [31:0] got_data, output bit tmo);
        int n;
        tmo = 0;
        arid = id; araddr = addr; arvalid = 1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        if (n == 50) tmo = 1;
        tick();
        arvalid = 0;
        rready = 1;
        n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        if (!rvalid) tmo = 1;
        got_id = rid;
        got_data = rdata;
        tick();
        rready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
        arid = 0; araddr = 0; awid = 0; awaddr = 0; wdata = 0; wstrb = 0;
        repeat (3) tick();
        total++;
        if ({rvalid, bvalid, arready, awready, wready} !== 5'b00111) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00111",
                     {rvalid, bvalid, arready, awready, wready});
        end
        total++;
        if ({rid, rdata, bid} !== 40'd0) begin
            bad++;
            $display("FAIL reset_data got rid=%h rdata=%h bid=%h exp 0",
                     rid, rdata, bid);
        end
        total++;
        if ({rresp, rlast, bresp} !== 5'b00100) begin
            bad++;
            $display("FAIL reset_const got=%b exp=00100",
                     {rresp, rlast, bresp});
        end
        reset = 0;
        tick();
    endtask

    task automatic test_write_read();
        logic [3:0]  gb, gi;
        logic [31:0] gd;
        bit          t1, t2;
        do_write(4'd1, 32'h100, 32'h12345678, 4'hF, 0, 0, gb, t1);
        total++;
        if (t1 || gb !== 4'd1) begin
            bad++;
            $display("FAIL wr_bid got=%h tmo=%0d exp=1", gb, t1);
        end
        do_read(4'd1, 32'h100, gi, gd, t2);
        total++;
        if (t2 || gi !== 4'd1 || gd !== 32'h12345678) begin
            bad++;
            $display("FAIL rd_basic got id=%h data=%h tmo=%0d exp 1/12345678",
                     gi, gd, t2);
        end
    endtask

    task automatic test_w_first();
        logic [3:0]  gb, gi;
        logic [31:0] gd;
        bit          t;
        do_write(4'd2, 32'h104, 32'h0, 4'hF, 0, 0, gb, t);
        wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1;
        tick();
        wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({wready, awready, bvalid} !== 3'b010) begin
                bad++;
                $display("FAIL wfirst_wait%0d got=%b exp=010", i,
                         {wready, awready, bvalid});
            end
            if (i < 2) tick();
        end
        awid = 4'd7; awaddr = 32'h104; awvalid = 1;
        tick();
        awvalid = 0;
        total++;
        if (bvalid !== 1'b1 || bid !== 4'd7) begin
            bad++;
            $display("FAIL wfirst_b got bvalid=%b bid=%h exp 1/7", bvalid, bid);
        end
        bready = 1;
        tick();
        bready = 0;
        model[12'h041] = 32'h00BB00DD;
        do_read(4'd3, 32'h104, gi, gd, t);
        total++;
        if (t || gd !== 32'h00BB00DD) begin
            bad++;
            $display("FAIL wfirst_data got=%h exp=00BB00DD", gd);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] gb;
        bit         t;
        bit [31:0]  exp_d [4];
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = $urandom;
            do_write(4'd0, 32'h300 + 32'(4 * i), exp_d[i], 4'hF, 0, 0, gb, t);
        end
        rready = 0;
        arvalid = 1;
        for (int i = 0; i < 4; i++) begin
            arid = 4'(4 + i);
            araddr = 32'h300 + 32'(4 * i);
            total++;
            if (arready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_arready%0d got=%b exp=1", i, arready);
            end
            tick();
        end
        araddr = 32'h310; arid = 4'hF;
        total++;
        if (arready !== 1'b0 || rvalid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_full got arready=%b rvalid=%b exp 0/1",
                     arready, rvalid);
        end
        tick();
        arvalid = 0;
        tick();
        total++;
        if (rid !== 4'd4 || rdata !== exp_d[0]) begin
            bad++;
            $display("FAIL b2b_stable got %h/%h exp 4/%h", rid, rdata, exp_d[0]);
        end
        rready = 1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rvalid !== 1'b1 || rid !== 4'(4 + i) || rdata !== exp_d[i]) begin
                bad++;
                $display("FAIL b2b_pop%0d got v=%b id=%h d=%h exp 1/%h/%h",
                         i, rvalid, rid, rdata, 4'(4 + i), exp_d[i]);
            end
            tick();
            if (i == 0) begin
                total++;
                if (arready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_rearm got=%b exp=1", arready);
                end
            end
        end
        total++;
        if (rvalid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain got rvalid=%b exp=0", rvalid);
        end
        rready = 0;
    endtask

    task automatic test_bypass();
        logic [3:0] gb;
        bit         t;
        do_write(4'd0, 32'h200, 32'h11223344, 4'hF, 0, 0, gb, t);
        wdata = 32'hFFFF0000; wstrb = 4'hC; wvalid = 1;
        tick();
        wvalid = 0;
        awid = 4'd3; awaddr = 32'h200; awvalid = 1;
        arid = 4'd2; araddr = 32'h200; arvalid = 1;
        total++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            bad++;
            $display("FAIL byp_ready got aw=%b ar=%b exp 1/1", awready, arready);
        end
        tick();
        awvalid = 0; arvalid = 0;
        model[12'h080] = 32'hFFFF3344;
        rready = 1; bready = 1;
        total++;
        if (rvalid !== 1'b1 || rid !== 4'd2 || rdata !== 32'hFFFF3344) begin
            bad++;
            $display("FAIL byp_data got v=%b id=%h d=%h exp 1/2/FFFF3344",
                     rvalid, rid, rdata);
        end
        total++;
        if (bvalid !== 1'b1 || bid !== 4'd3) begin
            bad++;
            $display("FAIL byp_b got v=%b id=%h exp 1/3", bvalid, bid);
        end
        tick();
        rready = 0; bready = 0;
    endtask

    task automatic test_random();
        logic [3:0]  gb, gi;
        logic [31:0] gd;
        bit          t;
        bit [31:0]   a, d;
        bit [3:0]    id, s;
        for (int i = 0; i < 16; i++) begin
            do_write(4'd0, 32'h400 + 32'(4 * i), $urandom, 4'hF, 0, 0, gb, t);
        end
        for (int k = 0; k < 150; k++) begin
            a = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'd0,
                 12'h100 + 12'($urandom_range(0, 15)), 2'($urandom)};
            id = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom);
                do_write(id, a, d, s, $urandom_range(0, 2),
                         $urandom_range(0, 3), gb, t);
                total++;
                if (t || gb !== id) begin
                    bad++;
                    $display("FAIL rnd_wr%0d got bid=%h tmo=%0d exp=%h",
                             k, gb, t, id);
                end
            end else begin
                do_read(id, a, gi, gd, t);
                total++;
                if (t || gi !== id || gd !== model[a[13:2]]) begin
                    bad++;
                    $display("FAIL rnd_rd%0d a=%h got %h/%h tmo=%0d exp %h/%h",
                             k, a, gi, gd, t, id, model[a[13:2]]);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic [3:0]  gi;
        logic [31:0] gd;
        bit          t;
        rready = 0; bready = 0;
        arvalid = 1; arid = 4'd9; araddr = 32'h100;
        tick();
        araddr = 32'h104;
        tick();
        arvalid = 0;
        awid = 4'd5; awaddr = 32'h108; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        model[12'h042] = 32'h5A5A5A5A;
        total++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre got rvalid=%b bvalid=%b exp 1/1",
                     rvalid, bvalid);
        end
        reset = 1;
        #1;
        total++;
        if ({rvalid, bvalid, arready, awready, wready} !== 5'b00111) begin
            bad++;
            $display("FAIL rst_async got=%b exp=00111",
                     {rvalid, bvalid, arready, awready, wready});
        end
        total++;
        if ({rid, rdata, bid} !== 40'd0) begin
            bad++;
            $display("FAIL rst_async_data got %h/%h/%h exp 0", rid, rdata, bid);
        end
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
                bad++;
                $display("FAIL rst_after%0d got rvalid=%b bvalid=%b exp 0/0",
                         i, rvalid, bvalid);
            end
        end
        do_read(4'd6, 32'h108, gi, gd, t);
        total++;
        if (t || gi !== 4'd6 || gd !== model[12'h042]) begin
            bad++;
            $display("FAIL rst_mem_kept got %h/%h exp 6/%h",
                     gi, gd, model[12'h042]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_w_first();
        test_back_to_back();
        test_bypass();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
